// File: rtl/jtcontra_dwnld_pkg.sv
// jtcontra_dwnld_pkg: shared FSM state type and active-low SDRAM byte-enable constants
package jtcontra_dwnld_pkg;
  typedef enum logic [1:0] {IDLE, SDRAM_WAIT, PROM_PULSE} state_t;
  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;
endpackage

// File: rtl/jtcontra_dwnld_skid.sv
// jtcontra_dwnld_skid: one-entry byte holder (clk, rst_n, load/clear in, in_addr/in_data in, addr/data/valid out); load wins over clear
module jtcontra_dwnld_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [24:0] in_addr,
  input  logic [7:0]  in_data,
  output logic [24:0] addr,
  output logic [7:0]  data,
  output logic        valid
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr <= in_addr;
      data <= in_data;
    end else if (clear) valid <= 1'b0;
endmodule

// File: rtl/jtcontra_dwnld.sv
// jtcontra_dwnld: ioctl byte stream -> SDRAM (prog_we/ack handshake) or PROM (prom_we pulse) writes with one-entry skid, sticky overrun, dwnld_busy; optional chksum output when JTCONTRA_DWNLD_CHKSUM_EN is defined
module jtcontra_dwnld
  import jtcontra_dwnld_pkg::*;
#(
  parameter logic [24:0] PROM_START = 25'h128_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        sdram_ack,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        prom_we,
  output logic        dwnld_busy,
`ifdef JTCONTRA_DWNLD_CHKSUM_EN
  output logic        overrun,
  output logic [15:0] chksum
`else
  output logic        overrun
`endif
);
  state_t state, state_nx;
  logic [24:0] sk_addr, src_addr;
  logic [7:0] sk_data, src_data, data_nx;
  logic [21:0] prom_off, addr_nx;
  logic [1:0] mask_nx;
  logic sk_valid, accept, retire, free, issue, src_prom, sk_load, sk_clear, drop;
  assign accept = downloading & ioctl_wr;
  assign retire = (state == SDRAM_WAIT && sdram_ack) || state == PROM_PULSE;
  assign free = state == IDLE || retire;
  assign issue = free & (sk_valid | accept);
  assign src_addr = sk_valid ? sk_addr : ioctl_addr;
  assign src_data = sk_valid ? sk_data : ioctl_data;
  assign src_prom = src_addr >= PROM_START;
  assign prom_off = 22'(src_addr - PROM_START);
  // a buffered byte always goes out first; a new byte arriving with it takes its place in the skid
  assign sk_load = accept & (free ? sk_valid : ~sk_valid);
  assign sk_clear = free & sk_valid;
  assign drop = accept & ~free & sk_valid;
  assign dwnld_busy = downloading | (state != IDLE) | sk_valid;
  jtcontra_dwnld_skid u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .load(sk_load),
    .clear(sk_clear),
    .in_addr(ioctl_addr),
    .in_data(ioctl_data),
    .addr(sk_addr),
    .data(sk_data),
    .valid(sk_valid)
  );
  always_comb begin
    state_nx = issue ? (src_prom ? PROM_PULSE : SDRAM_WAIT) : free ? IDLE : state;
    addr_nx = issue ? (src_prom ? prom_off : src_addr[22:1]) : prog_addr;
    data_nx = issue ? src_data : prog_data;
    mask_nx = issue ? (src_prom ? MASK_NONE : src_addr[0] ? MASK_HI : MASK_LO) : prog_mask;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      prog_we <= 1'b0;
      prom_we <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= MASK_NONE;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      prog_we <= state_nx == SDRAM_WAIT;
      prom_we <= state_nx == PROM_PULSE;
      prog_addr <= addr_nx;
      prog_data <= data_nx;
      prog_mask <= mask_nx;
      overrun <= overrun | drop;
    end
`ifdef JTCONTRA_DWNLD_CHKSUM_EN
  logic dl_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dl_q <= 1'b0;
      chksum <= '0;
    end else begin
      dl_q <= downloading;
      chksum <= (downloading && !dl_q ? 16'd0 : chksum) + (accept && !drop ? {8'd0, ioctl_data} : 16'd0);
    end
`endif
endmodule

// File: tb/tb_jtcontra_dwnld.sv
// tb_jtcontra_dwnld: randomized and directed checks of jtcontra_dwnld against an outstanding-write queue model
module tb_jtcontra_dwnld;
  localparam logic [24:0] PROM_START = 25'h128_000;
  logic clk = 1'b0, rst_n = 1'b0, downloading = 1'b0, ioctl_wr = 1'b0, sdram_ack = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_data = '0;
  logic [21:0] prog_addr;
  logic [7:0] prog_data;
  logic [1:0] prog_mask;
  logic prog_we, prom_we, dwnld_busy, overrun;
  logic [32:0] q[$];
  logic m_ovr = 1'b0, dl_prev = 1'b0;
  logic [15:0] m_sum = '0;
  int total = 0, bad = 0;
`ifdef JTCONTRA_DWNLD_CHKSUM_EN
  logic [15:0] chksum;
`endif
  jtcontra_dwnld #(.PROM_START(PROM_START)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .downloading(downloading),
    .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data),
    .ioctl_wr(ioctl_wr),
    .sdram_ack(sdram_ack),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_mask(prog_mask),
    .prog_we(prog_we),
    .prom_we(prom_we),
    .dwnld_busy(dwnld_busy),
`ifdef JTCONTRA_DWNLD_CHKSUM_EN
    .overrun(overrun),
    .chksum(chksum)
`else
    .overrun(overrun)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit is_prom(input logic [32:0] e);
    logic [24:0] a;
    a = e[32:8];
    return a >= PROM_START;
  endfunction
  function automatic logic [21:0] exp_addr(input logic [32:0] e);
    logic [24:0] a;
    a = e[32:8];
    return is_prom(e) ? 22'(a - PROM_START) : a[22:1];
  endfunction
  function automatic logic [1:0] exp_mask(input logic [32:0] e);
    logic [24:0] a;
    a = e[32:8];
    return a[0] ? 2'b01 : 2'b10;
  endfunction
  task automatic model_edge();
    bit ret;
    ret = q.size() > 0 && (is_prom(q[0]) || sdram_ack);
    if (downloading && !dl_prev) m_sum = '0;
    dl_prev = downloading;
    if (ret) void'(q.pop_front());
    if (downloading && ioctl_wr) begin
      if (q.size() < 2) begin
        q.push_back({ioctl_addr, ioctl_data});
        m_sum = m_sum + {8'd0, ioctl_data};
      end else m_ovr = 1'b1;
    end
  endtask
  task automatic check_all();
    chk("prog_we", prog_we, q.size() > 0 && !is_prom(q[0]));
    chk("prom_we", prom_we, q.size() > 0 && is_prom(q[0]));
    if (q.size() > 0) begin
      chk("prog_addr", prog_addr, exp_addr(q[0]));
      chk("prog_data", prog_data, q[0][7:0]);
      if (!is_prom(q[0])) chk("prog_mask", prog_mask, exp_mask(q[0]));
    end
    chk("overrun", overrun, m_ovr);
    chk("busy", dwnld_busy, downloading || q.size() > 0);
`ifdef JTCONTRA_DWNLD_CHKSUM_EN
    chk("chksum", chksum, m_sum);
`endif
  endtask
  task automatic cyc(input logic wr, input logic [24:0] a, input logic [7:0] d, input logic ack);
    ioctl_wr = wr;
    ioctl_addr = a;
    ioctl_data = d;
    sdram_ack = ack;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    ioctl_wr = 1'b0;
    sdram_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_prog_we", prog_we, 0);
    chk("rst_prom_we", prom_we, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_data", prog_data, 0);
    chk("rst_mask", prog_mask, 2'b11);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", dwnld_busy, downloading);
`ifdef JTCONTRA_DWNLD_CHKSUM_EN
    chk("rst_chksum", chksum, 0);
`endif
    q.delete();
    m_ovr = 1'b0;
    m_sum = '0;
    dl_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    downloading = 1'b1;
    cyc(1, 25'h00005, 8'hA5, 0);
    chk("sd_we", prog_we, 1);
    chk("sd_addr", prog_addr, 22'h2);
    chk("sd_mask", prog_mask, 2'b01);
    chk("sd_data", prog_data, 8'hA5);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("sd_we_drop", prog_we, 0);
    cyc(1, 25'h128003, 8'h0C, 0);
    chk("prom_pulse", prom_we, 1);
    chk("prom_addr", prog_addr, 22'h3);
    cyc(0, 0, 0, 0);
    chk("prom_end", prom_we, 0);
    cyc(1, 25'h00010, 8'h11, 0);
    cyc(1, 25'h00011, 8'h22, 0);
    cyc(1, 25'h00012, 8'h33, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    chk("b2b_overrun", overrun, 1);
    cyc(0, 0, 0, 1);
    chk("b2b_second", prog_data, 8'h22);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    do_reset();
    cyc(1, 25'h00100, 8'h44, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 25'h00101, 8'h55, 1);
    chk("same_we", prog_we, 1);
    cyc(0, 0, 0, 1);
    chk("same_overrun", overrun, 0);
    downloading = 1'b0;
    cyc(0, 0, 0, 0);
    downloading = 1'b1;
    cyc(1, 25'h00200, 8'hFF, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 25'h00201, 8'h02, 0);
    downloading = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("fall_busy", dwnld_busy, 1);
    cyc(0, 0, 0, 1);
    chk("fall_idle", dwnld_busy, 0);
`ifdef JTCONTRA_DWNLD_CHKSUM_EN
    chk("chksum_0101", chksum, 16'h0101);
`endif
    downloading = 1'b1;
    cyc(1, 25'h00300, 8'h66, 0);
    cyc(0, 0, 0, 0);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("post_rst_we", prog_we, 0);
    for (int n = 0; n < 3000; n++) begin
      logic [24:0] a;
      if (n % 700 == 699) do_reset();
      if ($urandom % 50 == 0) downloading = ~downloading;
      a = ($urandom % 2) ? 25'($urandom_range(0, 32'h127FFF)) : 25'($urandom_range(32'h128000, 32'h1FFFFFF));
      cyc($urandom % 3 == 0, a, 8'($urandom), $urandom % 3 == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
